// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the RV64 pipeline stages.
//   XLEN_DEFAULT : default datapath / address width
//   NOP_INSTR    : canonical NOP (addi x0, x0, 0), used for pipeline bubbles
//   OPC_*        : major opcode encodings used by decode and control
//   if_state_t   : instruction-fetch FSM state encoding
package riscv_pkg;

    localparam int          XLEN_DEFAULT = 64;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [6:0]  OPC_RTYPE    = 7'b0110011;
    localparam logic [6:0]  OPC_LOAD     = 7'b0000011;
    localparam logic [6:0]  OPC_STORE    = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request on the bus, waiting for acceptance
        ST_WAIT  = 2'd1,  // request accepted, waiting for the response
        ST_HOLD  = 2'd2   // response buffered while decode is stalled
    } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with rs1/rs2 extraction.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_flush               : force a bubble (highest priority)
//   i_stall               : hold current contents
//   i_load                : load i_pc / i_instr as a valid instruction
//   i_pc, i_instr         : incoming instruction and its PC
//   o_valid, o_pc, o_instr: registered IF/ID contents
//   o_rs1, o_rs2          : source register fields of o_instr
// With none of flush/stall/load asserted the register takes a bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instr,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2
);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_valid <= 1'b0;
            o_pc    <= '0;
            o_instr <= NOP_INSTR;
        end else if (i_stall) begin
            o_valid <= o_valid;
            o_pc    <= o_pc;
            o_instr <= o_instr;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_pc    <= i_pc;
            o_instr <= i_instr;
        end else begin
            o_valid <= 1'b0;
            o_pc    <= '0;
            o_instr <= NOP_INSTR;
        end
    end

    // Taken from the registered word so a bubble (NOP) yields x0/x0.
    assign o_rs1 = o_instr[19:15];
    assign o_rs2 = o_instr[24:20];

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, fetches over a
// valid/ready request channel with a separate response strobe, and
// loads the IF/ID register.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_pc_write, i_if_id_write: hazard-unit enables, 0 = stall
//   i_branch_taken/_target   : redirect + flush from EX/MEM
//   o_imem_req/_addr         : fetch request (word aligned address)
//   i_imem_ready             : request accepted when o_imem_req is also 1
//   i_imem_rvalid/_rdata     : response strobe and instruction word
//   o_if_id_*                : IF/ID contents and rs1/rs2 fields
//   o_dbg_state              : current fetch FSM state
// Handshake: a request transfers on a rising edge where o_imem_req and
// i_imem_ready are both 1; exactly one i_imem_rvalid pulse follows, at
// least one cycle later. Only one request is ever outstanding.
module if_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_pc_write,
    input  logic            i_if_id_write,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_if_id_valid,
    output logic [XLEN-1:0] o_if_id_pc,
    output logic [31:0]     o_if_id_instr,
    output logic [4:0]      o_if_id_rs1,
    output logic [4:0]      o_if_id_rs2,
    output logic [1:0]      o_dbg_state
);

    if_state_t       state_q;
    logic [XLEN-1:0] pc_q;
    logic            kill_q;   // outstanding response belongs to a flushed path
    logic [31:0]     buf_q;    // response parked while decode is stalled

    logic        stall;
    logic        flush;
    logic        handoff;
    logic [31:0] handoff_instr;

    assign stall = !i_pc_write || !i_if_id_write;
    assign flush = i_branch_taken;

    assign o_imem_req  = (state_q == ST_FETCH) && !i_rst;
    assign o_imem_addr = {pc_q[XLEN-1:2], 2'b00};
    assign o_dbg_state = state_q;

    always_comb begin
        handoff       = 1'b0;
        handoff_instr = i_imem_rdata;
        case (state_q)
            ST_WAIT: handoff = i_imem_rvalid && !kill_q && !flush && !stall;
            ST_HOLD: begin
                handoff       = !flush && !stall;
                handoff_instr = buf_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (i_imem_ready) begin
                        state_q <= ST_WAIT;
                        // Redirect in the acceptance cycle: the response
                        // already in flight is for the old path.
                        kill_q  <= flush;
                    end
                    if (flush) pc_q <= i_branch_target;
                end
                ST_WAIT: begin
                    if (i_imem_rvalid) begin
                        kill_q <= 1'b0;
                        if (flush) begin
                            pc_q    <= i_branch_target;
                            state_q <= ST_FETCH;
                        end else if (kill_q) begin
                            state_q <= ST_FETCH;
                        end else if (!stall) begin
                            pc_q    <= pc_q + XLEN'(4);
                            state_q <= ST_FETCH;
                        end else begin
                            buf_q   <= i_imem_rdata;
                            state_q <= ST_HOLD;
                        end
                    end else if (flush) begin
                        kill_q <= 1'b1;
                        pc_q   <= i_branch_target;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        buf_q   <= '0;
                        pc_q    <= i_branch_target;
                        state_q <= ST_FETCH;
                    end else if (!stall) begin
                        pc_q    <= pc_q + XLEN'(4);
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (flush),
        .i_stall (stall),
        .i_load  (handoff),
        .i_pc    (pc_q),
        .i_instr (handoff_instr),
        .o_valid (o_if_id_valid),
        .o_pc    (o_if_id_pc),
        .o_instr (o_if_id_instr),
        .o_rs1   (o_if_id_rs1),
        .o_rs2   (o_if_id_rs2)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage. Inputs are driven on the
// falling edge, outputs are checked on the following falling edge.
module tb_if_stage;

    localparam int          XLEN = 64;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [1:0]  S_FETCH = 2'd0;
    localparam logic [1:0]  S_WAIT  = 2'd1;
    localparam logic [1:0]  S_HOLD  = 2'd2;

    logic            clk = 1'b0;
    logic            rst;
    logic            pc_write;
    logic            if_id_write;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [31:0]     if_id_instr;
    logic [4:0]      if_id_rs1;
    logic [4:0]      if_id_rs2;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // clock / reset
    always #5 clk = ~clk;

    if_stage #(.XLEN(XLEN), .RESET_PC(64'h1000)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pc_write      (pc_write),
        .i_if_id_write   (if_id_write),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ready    (imem_ready),
        .i_imem_rvalid   (imem_rvalid),
        .i_imem_rdata    (imem_rdata),
        .o_if_id_valid   (if_id_valid),
        .o_if_id_pc      (if_id_pc),
        .o_if_id_instr   (if_id_instr),
        .o_if_id_rs1     (if_id_rs1),
        .o_if_id_rs2     (if_id_rs2),
        .o_dbg_state     (dbg_state)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [63:0] pc,
                            input logic [31:0] instr, input logic [4:0] rs1, input logic [4:0] rs2);
        chk({tag, "_valid"}, 64'(if_id_valid), 64'(v));
        chk({tag, "_pc"},    if_id_pc,         pc);
        chk({tag, "_instr"}, 64'(if_id_instr), 64'(instr));
        chk({tag, "_rs1"},   64'(if_id_rs1),   64'(rs1));
        chk({tag, "_rs2"},   64'(if_id_rs2),   64'(rs2));
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [63:0] addr);
        chk({tag, "_req"}, 64'(imem_req), 64'(req));
        if (req) chk({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        rst = 1'b1; pc_write = 1'b1; if_id_write = 1'b1;
        branch_taken = 1'b0; branch_target = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        // reset state
        tick(); tick();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk_ifid("rst", 1'b0, 64'h0, NOP, 5'd0, 5'd0);
        chk("rst_state", 64'(dbg_state), 64'(S_FETCH));

        // straight-line fetch from 0x1000
        rst = 1'b0;
        tick();
        chk_req("f0", 1'b1, 64'h1000);
        imem_ready = 1'b1;
        tick();
        chk_req("f0_acc", 1'b0, 64'h0);
        chk("f0_state", 64'(dbg_state), 64'(S_WAIT));
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_81B3;   // add x3,x1,x2
        tick();
        imem_rvalid = 1'b0;
        chk_ifid("f0_out", 1'b1, 64'h1000, 32'h0020_81B3, 5'd1, 5'd2);
        chk_req("f1", 1'b1, 64'h1004);
        tick();
        chk("f1_bubble", 64'(if_id_valid), 64'd0);
        chk_req("f1_acc", 1'b0, 64'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h00C5_8633;   // add x12,x11,x12
        tick();
        imem_rvalid = 1'b0;
        chk_ifid("f1_out", 1'b1, 64'h1004, 32'h00C5_8633, 5'd11, 5'd12);
        chk_req("f2", 1'b1, 64'h1008);

        // stall: response parked in HOLD, IF/ID frozen
        pc_write = 1'b0;
        tick();
        chk("st_wait_state", 64'(dbg_state), 64'(S_WAIT));
        chk("st_wait_pc", if_id_pc, 64'h1004);
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;   // addi x1,x0,10
        tick();
        imem_rvalid = 1'b0;
        chk("st_h1_state", 64'(dbg_state), 64'(S_HOLD));
        chk_ifid("st_h1", 1'b1, 64'h1004, 32'h00C5_8633, 5'd11, 5'd12);
        chk_req("st_h1", 1'b0, 64'h0);
        pc_write = 1'b1; if_id_write = 1'b0;
        tick();
        chk("st_h2_state", 64'(dbg_state), 64'(S_HOLD));
        chk("st_h2_pc", if_id_pc, 64'h1004);
        tick();
        chk("st_h3_state", 64'(dbg_state), 64'(S_HOLD));
        chk("st_h3_valid", 64'(if_id_valid), 64'd1);
        if_id_write = 1'b1;
        tick();
        chk_ifid("st_out", 1'b1, 64'h1008, 32'h00A0_0093, 5'd0, 5'd10);
        chk_req("st_next", 1'b1, 64'h100C);

        // flush while waiting; late response is killed
        tick();
        chk("fw_acc_state", 64'(dbg_state), 64'(S_WAIT));
        branch_taken = 1'b1; branch_target = 64'h2000;
        tick();
        branch_taken = 1'b0;
        chk("fw_state", 64'(dbg_state), 64'(S_WAIT));
        chk_req("fw_flush", 1'b0, 64'h0);
        chk("fw_bubble", 64'(if_id_valid), 64'd0);
        tick();
        chk_req("fw_idle", 1'b0, 64'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_8093;
        tick();
        imem_rvalid = 1'b0;
        chk_ifid("fw_drop", 1'b0, 64'h0, NOP, 5'd0, 5'd0);
        chk_req("fw_next", 1'b1, 64'h2000);

        // flush and stall together in HOLD
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0062_A023;   // sw x6,0(x5)
        tick();
        imem_rvalid = 1'b0;
        chk_ifid("fh_pre", 1'b1, 64'h2000, 32'h0062_A023, 5'd5, 5'd6);
        if_id_write = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_rvalid = 1'b0;
        chk("fh_state", 64'(dbg_state), 64'(S_HOLD));
        chk("fh_held_pc", if_id_pc, 64'h2000);
        branch_taken = 1'b1; branch_target = 64'h3000;
        tick();
        branch_taken = 1'b0; if_id_write = 1'b1;
        chk_ifid("fh_out", 1'b0, 64'h0, NOP, 5'd0, 5'd0);
        chk("fh_state2", 64'(dbg_state), 64'(S_FETCH));
        chk_req("fh_next", 1'b1, 64'h3000);

        // ready low: request held stable, flush retargets it
        imem_ready = 1'b0;
        tick();
        chk_req("nr1", 1'b1, 64'h3000);
        tick();
        chk_req("nr2", 1'b1, 64'h3000);
        branch_taken = 1'b1; branch_target = 64'h4002;
        tick();
        branch_taken = 1'b0;
        chk_req("nr3", 1'b1, 64'h4000);
        tick();
        chk_req("nr4", 1'b1, 64'h4000);
        chk("nr4_state", 64'(dbg_state), 64'(S_FETCH));

        // flush in the same cycle as the response
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_81B3;
        branch_taken = 1'b1; branch_target = 64'h5000;
        tick();
        imem_rvalid = 1'b0; branch_taken = 1'b0;
        chk("fr_valid", 64'(if_id_valid), 64'd0);
        chk_req("fr_next", 1'b1, 64'h5000);

        // PC wrap at the top of the address space
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk_req("wr_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h00C5_8633;
        tick();
        imem_rvalid = 1'b0;
        chk_ifid("wr_out", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00C5_8633, 5'd11, 5'd12);
        chk_req("wr_next", 1'b1, 64'h0);

        // reset mid-transaction
        imem_ready = 1'b1;
        tick();
        chk_req("mr_acc", 1'b0, 64'h0);
        rst = 1'b1; imem_ready = 1'b0;
        tick();
        chk_req("mr_rst", 1'b0, 64'h0);
        chk("mr_valid", 64'(if_id_valid), 64'd0);
        chk("mr_state", 64'(dbg_state), 64'(S_FETCH));
        rst = 1'b0;
        tick();
        chk_req("mr_after", 1'b1, 64'h1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
